dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder: valid/ready request, fixed-latency response.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses with rsp_err.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_next;

  logic [3:0]    cnt;
  logic          we_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic accept;
  logic access;
  logic trap;

  assign accept = (state == IDLE) && req_valid;
  assign access = (state == WAIT) && (cnt == '0);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q;
  logic err_q;
  logic unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:AW+2];
  assign trap    = misalign_q;
  assign rsp_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) misalign_q <= |req_addr[1:0];
      if (access) err_q <= misalign_q;
    end
  end
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign trap    = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter starts at LATENCY-1 so the access edge lands LATENCY edges after acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        we_q    <= req_we;
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (access) rsp_rdata <= (we_q || trap) ? '0 : mem[idx_q];
    end
  end

  // Storage is deliberately unreset; a reset forces IDLE so no access can fire.
  always_ff @(posedge clk) begin
    if (access && we_q && !trap) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes model expectations, monitor pops on rsp_valid.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [DEPTH];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  bit          hold  = 1'b0;
  bit          force_rdy = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: word index is (byte address / 4) mod DEPTH; stores merge enabled bytes.
  function automatic exp_t model(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
    exp_t        e;
    int unsigned i;
    i       = (addr / 4) % DEPTH;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    e.acc   = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((addr % 4) != 0) begin
      e.err = 1'b1;
      return e;
    end
`endif
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[i][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      e.rdata = mdl[i];
    end
    return e;
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=not_ready required=ready addr=%h", addr);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e     = model(we, addr, wdata, be);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  initial forever begin
    @(negedge clk);
    rsp_ready = hold ? force_rdy : ($urandom_range(0, 3) != 0);
  end

  // Monitor: one pop per response, on the first sample where rsp_valid is high.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && rsp_valid && !prev) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp actual=valid required=none rdata=%h", rsp_rdata);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("latency", cyc - e.acc, LAT);
        end
      end
      prev = rsp_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_word;
    int          n;

    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    chk("rst_busy",      {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int unsigned i = 0; i < DEPTH; i++)
      issue(1'b1, i * 4, $urandom, 4'hF);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    issue(1'b1, 32'h10, 32'h11223344, 4'hF);
    issue(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    issue(1'b1, 32'h10, 32'h12345678, 4'h0);
    issue(1'b0, 32'h10, 32'h0, 4'h3);
    issue(1'b1, 32'h400, 32'h00000055, 4'hF);
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    issue(1'b0, 32'h13, 32'h0, 4'h0);
    issue(1'b1, 32'h13, 32'h99999999, 4'hF);
    issue(1'b0, 32'h10, 32'h0, 4'h0);

    // Backpressure: hold rsp_ready low, poke a store that must be ignored.
    wait_idle();
    hold      = 1'b1;
    force_rdy = 1'b0;
    exp_word  = mdl[(32'h40 / 4) % DEPTH];
    issue(1'b0, 32'h40, 32'h0, 4'hF);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, exp_word);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_busy",      {31'b0, busy}, 32'd1);
      if (k == 1) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = ~exp_word;
        req_be    = 4'hF;
      end
      if (k == 2) req_valid = 1'b0;
      @(negedge clk);
    end
    force_rdy = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("release_req_ready", {31'b0, req_ready}, 32'd1);
    chk("release_busy",      {31'b0, busy}, 32'd0);
    hold      = 1'b0;
    force_rdy = 1'b0;
    issue(1'b0, 32'h40, 32'h0, 4'h0);

    // Reset mid-WAIT on a store: aborted, no write, outputs to reset values.
    issue(1'b1, 32'h20, 32'h0, 4'hF);
    wait_idle();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFEF00D;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait_busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    chk("abort_rsp_err",   {31'b0, rsp_err}, 32'd0);
    chk("abort_busy",      {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 4'h0);

    for (int k = 0; k < 300; k++) begin
      issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0)
        issue(1'b0, {$urandom_range(0, 63), 2'b00}, 32'h0, 4'h0);
    end

    wait_idle();
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
